// File: rtl/ula_md_pkg.sv
// Shared encodings for the EX-stage multiply/divide unit: opcodes, HI/LO read
// selects and the iteration FSM states.
package ula_md_pkg;

    localparam int MD_OP_W  = 3;
    localparam int RD_SEL_W = 2;

    typedef enum logic [MD_OP_W-1:0] {
        MD_NONE  = 3'b000,
        MD_MULT  = 3'b001,
        MD_MULTU = 3'b010,
        MD_DIV   = 3'b011,
        MD_DIVU  = 3'b100,
        MD_MTHI  = 3'b101,
        MD_MTLO  = 3'b110,
        MD_RSVD  = 3'b111
    } md_op_e;

    typedef enum logic [RD_SEL_W-1:0] {
        RD_NONE = 2'b00,
        RD_HI   = 2'b01,
        RD_LO   = 2'b10
    } rd_sel_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DIV  = 2'b10,
        ST_FIX  = 2'b11
    } md_state_e;

endpackage

// File: rtl/ula_muldiv_if.sv
// Control/operand/result bundle between the EX-stage pipeline and the
// multiply/divide unit.
interface ula_muldiv_if #(
    parameter int WIDTH = 32
);
    import ula_md_pkg::*;

    logic [MD_OP_W-1:0]  md_op;
    logic [WIDTH-1:0]    In1;
    logic [WIDTH-1:0]    In2;
    logic                flush;
    logic [RD_SEL_W-1:0] rd_sel;
    logic [WIDTH-1:0]    rd_data;
    logic                busy;
    logic                done;
    logic                md_stall;
    logic [WIDTH-1:0]    hi_o;
    logic [WIDTH-1:0]    lo_o;

    modport master (
        output md_op, In1, In2, flush, rd_sel,
        input  rd_data, busy, done, md_stall, hi_o, lo_o
    );

    modport slave (
        input  md_op, In1, In2, flush, rd_sel,
        output rd_data, busy, done, md_stall, hi_o, lo_o
    );

endinterface

// File: rtl/ula_md_step.sv
// One iteration of the multiply/divide datapath: a shift-add multiply step or
// a restoring shift-subtract divide step on the {upper, lower} accumulator.
module ula_md_step #(
    parameter int WIDTH = 32
) (
    input  logic                 is_div,
    input  logic [2*WIDTH-1:0]   acc,
    input  logic [WIDTH-1:0]     opnd,
    output logic [2*WIDTH-1:0]   acc_nx
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] diff;

    always_comb begin
        sum    = '0;
        rem_sh = '0;
        diff   = '0;
        acc_nx = acc;
        if (!is_div) begin
            // Multiplier sits in the low half; its LSB gates the add, carry lands in the top bit.
            sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
            acc_nx = {sum, acc[WIDTH-1:1]};
        end else begin
            // Partial remainder stays below the divisor, so the difference always fits WIDTH bits.
            rem_sh = acc[2*WIDTH-1:WIDTH-1];
            diff   = rem_sh[WIDTH-1:0] - opnd;
            if (rem_sh >= {1'b0, opnd}) begin
                acc_nx = {diff, acc[WIDTH-2:0], 1'b1};
            end else begin
                acc_nx = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/ula_muldiv.sv
// Iterative multiply/divide unit owning HI/LO; runs WIDTH steps on operand
// magnitudes and fixes the result sign in a final cycle.
module ula_muldiv
    import ula_md_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    ula_muldiv_if.slave  bus
);

    localparam int CNT_W = $clog2(WIDTH);

    md_state_e               state, state_nx;
    md_op_e                  op;
    logic [CNT_W-1:0]        cnt;
    logic [2*WIDTH-1:0]      acc, acc_nx;
    logic [WIDTH-1:0]        opnd;
    logic [WIDTH-1:0]        hi, lo;
    logic [WIDTH-1:0]        fix_hi, fix_lo;
    logic signed [WIDTH-1:0] in1_s, in2_s;
    logic                    is_div, neg_q, neg_r, done_r;
    logic                    op_signed, busy;
    logic                    ld_mul, ld_div, step_en, wr_fix, wr_div0, wr_hi, wr_lo;

    function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v, input logic sgn);
        return (sgn && (v < 0)) ? -v : v;
    endfunction

    function automatic logic [WIDTH-1:0] cneg_w(input logic [WIDTH-1:0] v, input logic n);
        return n ? -v : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] cneg_2w(input logic [2*WIDTH-1:0] v, input logic n);
        return n ? -v : v;
    endfunction

    assign op        = md_op_e'(bus.md_op);
    assign in1_s     = bus.In1;
    assign in2_s     = bus.In2;
    assign op_signed = (op == MD_MULT) || (op == MD_DIV);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        ld_mul   = 1'b0;
        ld_div   = 1'b0;
        step_en  = 1'b0;
        wr_fix   = 1'b0;
        wr_div0  = 1'b0;
        wr_hi    = 1'b0;
        wr_lo    = 1'b0;
        if (bus.flush) begin
            state_nx = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    case (op)
                        MD_MULT, MD_MULTU: begin
                            ld_mul   = 1'b1;
                            state_nx = ST_MUL;
                        end
                        MD_DIV, MD_DIVU: begin
                            if (bus.In2 == '0) begin
                                wr_div0 = 1'b1;
                            end else begin
                                ld_div   = 1'b1;
                                state_nx = ST_DIV;
                            end
                        end
                        MD_MTHI: wr_hi = 1'b1;
                        MD_MTLO: wr_lo = 1'b1;
                        default: ;
                    endcase
                end
                ST_MUL, ST_DIV: begin
                    step_en = 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1)) state_nx = ST_FIX;
                end
                ST_FIX: begin
                    wr_fix   = 1'b1;
                    state_nx = ST_IDLE;
                end
                default: state_nx = ST_IDLE;
            endcase
        end
    end

    ula_md_step #(.WIDTH(WIDTH)) u_step (
        .is_div (is_div),
        .acc    (acc),
        .opnd   (opnd),
        .acc_nx (acc_nx)
    );

    // Operand/accumulator path: only meaningful while an operation is in flight.
    always_ff @(posedge clk) begin
        if (ld_mul) begin
            acc    <= {{WIDTH{1'b0}}, mag(in2_s, op_signed)};
            opnd   <= mag(in1_s, op_signed);
            is_div <= 1'b0;
            neg_q  <= op_signed & (bus.In1[WIDTH-1] ^ bus.In2[WIDTH-1]);
            neg_r  <= 1'b0;
        end else if (ld_div) begin
            acc    <= {{WIDTH{1'b0}}, mag(in1_s, op_signed)};
            opnd   <= mag(in2_s, op_signed);
            is_div <= 1'b1;
            neg_q  <= op_signed & (bus.In1[WIDTH-1] ^ bus.In2[WIDTH-1]);
            neg_r  <= op_signed & bus.In1[WIDTH-1];
        end else if (step_en) begin
            acc <= acc_nx;
        end
    end

    always_comb begin
        fix_hi = cneg_w(acc[2*WIDTH-1:WIDTH], neg_r);
        fix_lo = cneg_w(acc[WIDTH-1:0], neg_q);
        if (!is_div) {fix_hi, fix_lo} = cneg_2w(acc, neg_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt    <= '0;
            hi     <= '0;
            lo     <= '0;
            done_r <= 1'b0;
        end else begin
            done_r <= wr_fix | wr_div0;
            if (ld_mul || ld_div) cnt <= '0;
            else if (step_en)     cnt <= cnt + 1'b1;
            if (wr_fix) begin
                hi <= fix_hi;
                lo <= fix_lo;
            end else if (wr_div0) begin
                hi <= bus.In1;
                lo <= '1;
            end else if (wr_hi) begin
                hi <= bus.In1;
            end else if (wr_lo) begin
                lo <= bus.In1;
            end
        end
    end

    assign busy         = (state != ST_IDLE);
    assign bus.busy     = busy;
    assign bus.done     = done_r;
    assign bus.hi_o     = hi;
    assign bus.lo_o     = lo;
    assign bus.md_stall = busy & (((op != MD_NONE) && (op != MD_RSVD)) || (bus.rd_sel != RD_NONE));
    assign bus.rd_data  = (bus.rd_sel == RD_HI) ? hi :
                          (bus.rd_sel == RD_LO) ? lo : '0;

endmodule

// File: doc/ula_muldiv.md
Name: ula_muldiv

Overview:
Iterative multiply/divide unit in the EX stage, beside the ALU. It consumes the same rs/rt operands as the ALU and owns the architectural HI/LO registers. Its read port is muxed downstream with the ALU result for MFHI/MFLO. It raises a stall request so the pipeline holds while an operation is in flight.

Parameters:
WIDTH, 32, operand and HI/LO width; the iteration count equals WIDTH.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous active-low reset
md_op  in  3  operation code from control; see package encodings
In1  in  WIDTH  rs operand; dividend/multiplicand; MTHI/MTLO source
In2  in  WIDTH  rt operand; divisor/multiplier
flush  in  1  abort any in-flight operation; pipeline flush
rd_sel  in  2  00 none, 01 read HI, 10 read LO
rd_data  out  WIDTH  combinational HI or LO per rd_sel; 0 when rd_sel is 00
busy  out  1  high while an iterative operation is in flight
done  out  1  one-cycle pulse when HI/LO receive a MULT/DIV result
md_stall  out  1  busy & ((md_op != NONE) | (rd_sel != 00))
hi_o  out  WIDTH  current HI register
lo_o  out  WIDTH  current LO register

Behaviour:
- Reset (rst_n low at a clk edge): HI=0, LO=0, state IDLE, busy=0, done=0, iteration counter=0. Reset mid-operation discards the partial result.
- States: IDLE, MUL, DIV, FIX.
- IDLE actions:
  - MULT/MULTU: load |In1|, |In2| (absolute values for signed, raw for unsigned), latch the result sign, clear the 2*WIDTH accumulator, go to MUL.
  - DIV/DIVU: if In2==0, write the special result next edge (see below), pulse done, stay IDLE. Otherwise load magnitudes, latch the quotient sign (sign In1 ^ sign In2) and remainder sign (sign In1), go to DIV.
  - MTHI/MTLO: write In1 to HI (resp. LO) at the next edge. No busy, no done.
- MUL: one shift-add step per cycle for WIDTH cycles, then FIX.
- DIV: one restoring shift-subtract step per cycle for WIDTH cycles, then FIX.
- FIX: apply two's-complement negation per the latched signs. Write {HI,LO} (MUL: HI=upper, LO=lower; DIV: LO=quotient, HI=remainder). Return to IDLE.
- done: high for exactly the one cycle after the FIX edge; HI/LO already show the new values.
- Latency: op accepted at edge T. busy is high from T+1 through the FIX edge at T+WIDTH+1, i.e. WIDTH+1 cycles. done is high during cycle T+WIDTH+2.
- busy=1 in MUL, DIV and FIX.
- New md_op while busy: ignored (not queued). md_stall asserts so the pipeline holds the instruction and re-presents it when busy drops.
- MFHI/MFLO while busy: md_stall asserts; rd_data shows the old HI/LO and must not be consumed.
- Divide by zero (DIV or DIVU): LO=all ones, HI=In1, done pulses the next cycle, no busy.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. Wrap-around falls out of the magnitude path; no trap.
- flush: in any state, return to IDLE at the next edge. HI/LO unchanged, no done. flush has priority over a same-cycle md_op. flush in FIX cancels the write.
- MTHI/MTLO during the done cycle: accepted normally and overwrites the freshly written register.

Decomposition:
- Package ula_md_pkg:
  - md_op encodings: NONE=000, MULT=001, MULTU=010, DIV=011, DIVU=100, MTHI=101, MTLO=110; 111 is reserved and treated as NONE.
  - rd_sel encodings.
  - State enum.
- One sub-module, ula_md_step: a combinational single-iteration datapath for one shift-add or one restoring shift-subtract step. The parent holds the counter, FSM, sign latches and HI/LO.

Test Plan:
- Reset, then MULT In1=0xFFFFFFFE (-2), In2=3 -> busy for 33 cycles; done at T+34; HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001. Then rd_sel=01 -> rd_data=0xFFFFFFFE.
- DIV -7/2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). DIVU 7/0 -> LO=0xFFFFFFFF, HI=7, done the next cycle, busy never set.
- DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0. MTHI 0x1234 then MTLO 0x5678 -> hi_o=0x1234, lo_o=0x5678 one cycle later each.
- Start MULT 5x5, assert MFLO (rd_sel=10) at cycle 10 -> md_stall=1 until done; after done, rd_data=25. A second MULT issued at cycle 5 is ignored.
- Start DIVU 100/3, pulse flush at cycle 12 -> busy=0 next cycle, no done, HI/LO keep prior values. Separately, rst_n low mid-MUL -> HI=LO=0, busy=0.
